pe_output_writer: RTL and testbench
===================================

// Module: pe_output_writer
// PURPOSE
//  Write-side counterpart of the PE dispatcher's ROM readers. On end_conv_layer it snapshots all
//  2**log_n_add accumulator outputs, narrows each to 2**log_bit_width bits with signed saturation
//  (optional ReLU), and writes them one per accepted cycle to the result RAM at consecutive
//  addresses. Sits between the PE accumulator bank (output_reuse) and the layer-result memory.
// PARAMETERS
//  log_n_add      2   log2 lane count (accumulators per PE)
//  log_bit_width  3   log2 output word width W=2**log_bit_width; input lane width 2W
//  log_ram_size   16  result RAM address width
//  relu_en        0   1: negative results written as 0
// PORTS
//  clk             in   1                                clock, rising edge
//  rst             in   1                                asynchronous reset, active-low
//  end_conv_layer  in   1                                layer-complete level from dispatcher
//  acc_in          in   (2**log_n_add)*(2**(log_bit_width+1)) accumulator outputs, lane i at [i*2W +: 2W]
//  load_base_addr  in   1                                load init_base_addr into write pointer
//  init_base_addr  in   log_ram_size                     first write address of next layer
//  wr_ready        in   1                                RAM accepts write this cycle
//  wr_en           out  1                                write valid
//  wr_addr         out  log_ram_size                     write address
//  wr_data         out  2**log_bit_width                 saturated lane value
//  busy            out  1                                snapshot held / writes pending
//  done            out  1                                one-cycle pulse after last lane accepted
//  overflow        out  1                                sticky: layer end arrived while busy
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; wr_en/busy/done/overflow=0, wr_addr=0, wr_data=0,
//    lane ptr=0, snapshot cleared, end_conv_layer edge register=0. Mid-write reset aborts; no further writes.
//  - States: IDLE -> WRITE -> DONE -> IDLE.
//  - IDLE: trigger = rising edge of end_conv_layer (registered previous value). At trigger edge t
//    capture all lanes of acc_in, ptr=0; at t+1 wr_en=1, wr_addr=base, wr_data=sat(lane0), busy=1.
//  - WRITE: valid/ready: a write is accepted on a cycle with wr_en&wr_ready. While wr_ready=0,
//    wr_en, wr_addr, wr_data held stable. On accept of lane k<N-1: next cycle lane k+1, addr+1.
//    On accept of lane N-1: wr_en=0, go DONE.  Throughput 1 lane/cycle with wr_ready=1.
//  - DONE: done=1 for exactly one cycle, busy=0, base advanced by N (next layer contiguous); -> IDLE.
//  - Address arithmetic modulo 2**log_ram_size (base+N wraps silently).
//  - load_base_addr honoured only in IDLE; ignored in WRITE/DONE. Load and trigger in same IDLE
//    cycle: loaded address used for this layer.
//  - end_conv_layer rising edge while not IDLE: ignored, overflow set (cleared only by reset).
//    Held-high end_conv_layer does not retrigger; needs a low cycle first.
//  - Saturation: lane is 2W-bit two's complement. >2**(W-1)-1 -> 2**(W-1)-1; < -2**(W-1) -> -2**(W-1);
//    else low W bits. relu_en=1: negative -> 0 after saturation. Pure combinational on snapshot.
//  - acc_in changes after capture have no effect on the layer being written.
// STRUCTURE
//  - Shared include (pe_defines): lane width 2**(log_bit_width+1), word width, lane count
//    2**log_n_add, state encodings — same values used by the PE accumulators.
//  - One sub-module: sat_narrow #(in_w,out_w,relu_en) — combinational signed saturator, one
//    instance per lane on the snapshot, output muxed by ptr.
//  - Top: edge detect, FSM, lane pointer, address register, snapshot registers.
// TESTING (defaults: N=4, W=8)
//  1 base=0x0010 loaded, acc={0x0042,0x0123,0xFF80,0xFE00}, end pulse, wr_ready=1 -> writes
//    (0x0010,0x42),(0x0011,0x7F),(0x0012,0x80),(0x0013,0x80) on 4 consecutive cycles, done next cycle.
//  2 Same with relu_en=1 -> data 0x42,0x7F,0x00,0x00.
//  3 wr_ready low 3 cycles on lane 1 -> lane 1 addr/data held, no duplicate/skipped writes, 4 writes total.
//  4 Second end pulse during WRITE -> overflow=1 sticky, only 4 writes; following layer from IDLE
//    writes at 0x0014..0x0017; base=0xFFFE -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
//  5 rst low after lane 1 accepted -> outputs zero immediately (async), no writes until next trigger.
//  6 end_conv_layer held high 10 cycles -> exactly one layer (4 writes, one done pulse).

Source files
------------

// File: rtl/pe_output_writer_pkg.sv
// Shared definitions for the PE output writer: default geometry,
// FSM state encoding and width helpers used by the PE accumulator side too.
package pe_output_writer_pkg;

  localparam int DEF_LOG_N_ADD     = 2;
  localparam int DEF_LOG_BIT_WIDTH = 3;
  localparam int DEF_LOG_RAM_SIZE  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Output word width W = 2**log_bit_width.
  function automatic int word_w(input int log_bit_width);
    return 1 << log_bit_width;
  endfunction

  // Accumulator lane width 2W.
  function automatic int lane_w(input int log_bit_width);
    return 1 << (log_bit_width + 1);
  endfunction

  // Number of accumulator lanes per PE.
  function automatic int lane_cnt(input int log_n_add);
    return 1 << log_n_add;
  endfunction

endpackage

// File: rtl/pe_output_writer_sat_narrow.sv
// Combinational signed saturator: narrows an in_w-bit two's complement value
// to out_w bits, clamping to the representable range, with optional ReLU.
module sat_narrow #(
  parameter int in_w    = 16,
  parameter int out_w   = 8,
  parameter bit relu_en = 1'b0
) (
  input  logic [in_w-1:0]  din,
  output logic [out_w-1:0] dout
);

  localparam logic [out_w-1:0] MAX_C = {1'b0, {(out_w - 1){1'b1}}};
  localparam logic [out_w-1:0] MIN_C = {1'b1, {(out_w - 1){1'b0}}};

  // Bits that must all equal the sign for the value to fit in out_w bits.
  logic [in_w-out_w:0] top_s;
  logic [out_w-1:0]    sat_s;

  assign top_s = din[in_w-1:out_w-1];

  // Clamp out-of-range values to the nearest representable extreme.
  always_comb begin
    sat_s = din[out_w-1:0];
    if ((&top_s) || !(|top_s)) begin
      sat_s = din[out_w-1:0];
    end else if (din[in_w-1]) begin
      sat_s = MIN_C;
    end else begin
      sat_s = MAX_C;
    end
  end

  // Optional ReLU applied after saturation.
  always_comb begin
    dout = sat_s;
    if (relu_en && sat_s[out_w-1]) begin
      dout = '0;
    end else begin
      dout = sat_s;
    end
  end

endmodule

// File: rtl/pe_output_writer.sv
// PE output writer: on a rising edge of end_conv_layer it snapshots every
// accumulator lane and streams the saturated lanes to the result RAM, one per
// accepted valid/ready handshake, at consecutive addresses from the layer base.
module pe_output_writer
  import pe_output_writer_pkg::*;
#(
  parameter int log_n_add     = DEF_LOG_N_ADD,
  parameter int log_bit_width = DEF_LOG_BIT_WIDTH,
  parameter int log_ram_size  = DEF_LOG_RAM_SIZE,
  parameter int relu_en       = 0
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic                                                      end_conv_layer,
  input  logic [(1 << log_n_add) * (1 << (log_bit_width + 1))-1:0]  acc_in,
  input  logic                                                      load_base_addr,
  input  logic [log_ram_size-1:0]                                   init_base_addr,
  input  logic                                                      wr_ready,
  output logic                                                      wr_en,
  output logic [log_ram_size-1:0]                                   wr_addr,
  output logic [(1 << log_bit_width)-1:0]                           wr_data,
  output logic                                                      busy,
  output logic                                                      done,
  output logic                                                      overflow
);

  localparam int W  = word_w(log_bit_width);
  localparam int LW = lane_w(log_bit_width);
  localparam int N  = lane_cnt(log_n_add);

  localparam logic [log_n_add-1:0]    LAST_PTR = log_n_add'(N - 1);
  localparam logic [log_n_add-1:0]    PTR_ONE  = log_n_add'(1);
  localparam logic [log_ram_size-1:0] ADDR_ONE = log_ram_size'(1);
  localparam logic [log_ram_size-1:0] N_ADDR   = log_ram_size'(N);

  state_e                     state_q, state_d;
  logic [N-1:0][LW-1:0]       snap_q, snap_d;
  logic [log_n_add-1:0]       ptr_q, ptr_d;
  logic [log_ram_size-1:0]    base_q, base_d;
  logic [log_ram_size-1:0]    wr_addr_q, wr_addr_d;
  logic                       wr_en_q, wr_en_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       overflow_q, overflow_d;
  logic                       end_q, end_d;

  logic                       trig_s;
  logic                       accept_s;
  logic [W-1:0]               sat_s [N];

  assign end_d    = end_conv_layer;
  assign trig_s   = end_conv_layer & ~end_q;
  assign accept_s = wr_en_q & wr_ready;

  // One saturator per snapshot lane; the lane pointer selects the one on the bus.
  for (genvar i = 0; i < N; i++) begin : g_sat
    sat_narrow #(
      .in_w   (LW),
      .out_w  (W),
      .relu_en(relu_en != 0)
    ) u_sat (
      .din (snap_q[i]),
      .dout(sat_s[i])
    );
  end

  // Layer sequencing: capture on trigger, advance on each accepted write, advance base at the end.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    ptr_d     = ptr_q;
    base_d    = base_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_base_addr) begin
          base_d = init_base_addr;
        end else begin
          base_d = base_q;
        end
        if (trig_s) begin
          snap_d  = acc_in;
          ptr_d   = '0;
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_WRITE;
          // A same-cycle load takes effect for the layer being started.
          if (load_base_addr) begin
            wr_addr_d = init_base_addr;
          end else begin
            wr_addr_d = base_q;
          end
        end else begin
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      ST_WRITE: begin
        if (accept_s) begin
          if (ptr_q == LAST_PTR) begin
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            base_d  = base_q + N_ADDR;
            state_d = ST_DONE;
          end else begin
            ptr_d     = ptr_q + PTR_ONE;
            wr_addr_d = wr_addr_q + ADDR_ONE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // A layer end arriving while a layer is still in flight is dropped and latched as overflow.
  always_comb begin
    overflow_d = overflow_q;
    if (trig_s && (state_q != ST_IDLE)) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      ptr_q      <= '0;
      base_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      ptr_q      <= ptr_d;
      base_q     <= base_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      end_q      <= end_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_en_q ? sat_s[ptr_q] : '0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pe_output_writer.sv
// Directed bench for pe_output_writer (N=4 lanes, W=8): basic layer, ReLU,
// backpressure, overflow/contiguous base/wrap, mid-write reset, held trigger.
module tb_pe_output_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        end_conv_layer;
  logic [63:0] acc_in;
  logic        load_base_addr;
  logic [15:0] init_base_addr;
  logic        wr_ready;

  logic        wr_en, busy, done, overflow;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        r_wr_en, r_busy, r_done, r_overflow;
  logic [15:0] r_wr_addr;
  logic [7:0]  r_wr_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  logic [7:0]  rd[$];
  int          wc[$];
  int          done_cnt;
  int          done_cyc;

  localparam logic [63:0] ACC_A = {16'hFE00, 16'hFF80, 16'h0123, 16'h0042};

  pe_output_writer #(.relu_en(0)) dut (
    .clk(clk), .rst(rst), .end_conv_layer(end_conv_layer), .acc_in(acc_in),
    .load_base_addr(load_base_addr), .init_base_addr(init_base_addr), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .overflow(overflow)
  );

  pe_output_writer #(.relu_en(1)) dut_relu (
    .clk(clk), .rst(rst), .end_conv_layer(end_conv_layer), .acc_in(acc_in),
    .load_base_addr(load_base_addr), .init_base_addr(init_base_addr), .wr_ready(wr_ready),
    .wr_en(r_wr_en), .wr_addr(r_wr_addr), .wr_data(r_wr_data), .busy(r_busy), .done(r_done),
    .overflow(r_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write/done log sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst && wr_en && wr_ready) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wc.push_back(cyc);
    end
    if (rst && r_wr_en && wr_ready) rd.push_back(r_wr_data);
    if (rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); rd.delete(); wc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic load_base(input logic [15:0] a);
    init_base_addr = a;
    load_base_addr = 1'b1;
    step();
    load_base_addr = 1'b0;
  endtask

  task automatic pulse_end();
    end_conv_layer = 1'b1;
    step();
    end_conv_layer = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string nm);
    for (int i = 0; i < max_cyc && done_cnt == 0; i++) step();
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_done: no done pulse within %0d cycles", nm, max_cyc);
    end
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; end_conv_layer = 1'b0; acc_in = '0; load_base_addr = 1'b0;
    init_base_addr = '0; wr_ready = 1'b1;
    #3;
    checks++;
    if ({wr_en, busy, done, overflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {wr_en, busy, done, overflow});
    end
    checks++;
    if (wr_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", wr_addr); end
    checks++;
    if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", wr_data); end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] exp_d[4] = '{8'h42, 8'h7F, 8'h80, 8'h80};
    clear_log();
    acc_in = ACC_A;
    load_base(16'h0010);
    pulse_end();
    checks++;
    if ({wr_en, busy, wr_addr, wr_data} !== {1'b1, 1'b1, 16'h0010, 8'h42}) begin
      errors++;
      $display("FAIL basic_first: en=%b busy=%b addr=%h data=%h want 1 1 0010 42", wr_en, busy, wr_addr, wr_data);
    end
    acc_in = 64'h7FFF_7FFF_7FFF_7FFF;   // must not disturb the captured layer
    wait_done(20, "basic");
    checks++;
    if (wa.size() != 4) begin errors++; $display("FAIL basic_count: got %0d writes want 4", wa.size()); end
    for (int k = 0; k < 4 && k < wa.size(); k++) begin
      checks++;
      if (wa[k] !== 16'h0010 + 16'(k) || wd[k] !== exp_d[k] || wc[k] != wc[0] + k) begin
        errors++;
        $display("FAIL basic_w%0d: addr=%h data=%h cyc+%0d want %h %h +%0d", k, wa[k], wd[k], wc[k] - wc[0],
                 16'h0010 + 16'(k), exp_d[k], k);
      end
    end
    checks++;
    if (wc.size() == 4 && done_cyc != wc[3] + 1) begin
      errors++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc, wc[3] + 1);
    end
    checks++;
    if ({busy, overflow, done_cnt == 1} !== 3'b001) begin
      errors++; $display("FAIL basic_end: busy=%b ovf=%b done_cnt=%0d want 0 0 1", busy, overflow, done_cnt);
    end
  endtask

  task automatic test_relu();
    logic [7:0] exp_r[4] = '{8'h42, 8'h7F, 8'h00, 8'h00};
    clear_log();
    acc_in = ACC_A;
    load_base(16'h0020);
    pulse_end();
    wait_done(20, "relu");
    checks++;
    if (rd.size() != 4) begin errors++; $display("FAIL relu_count: got %0d want 4", rd.size()); end
    for (int k = 0; k < 4 && k < rd.size(); k++) begin
      checks++;
      if (rd[k] !== exp_r[k]) begin errors++; $display("FAIL relu_w%0d: got %h want %h", k, rd[k], exp_r[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d[4] = '{8'h42, 8'h7F, 8'h80, 8'h80};
    clear_log();
    acc_in = ACC_A;
    load_base(16'h0030);
    pulse_end();
    step();                 // lane 0 accepted, lane 1 presented
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'h0031, 8'h7F}) begin
        errors++; $display("FAIL bp_hold%0d: en=%b addr=%h data=%h want 1 0031 7f", i, wr_en, wr_addr, wr_data);
      end
    end
    wr_ready = 1'b1;
    wait_done(20, "bp");
    checks++;
    if (wa.size() != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", wa.size()); end
    for (int k = 0; k < 4 && k < wa.size(); k++) begin
      checks++;
      if (wa[k] !== 16'h0030 + 16'(k) || wd[k] !== exp_d[k]) begin
        errors++; $display("FAIL bp_w%0d: addr=%h data=%h want %h %h", k, wa[k], wd[k], 16'h0030 + 16'(k), exp_d[k]);
      end
    end
  endtask

  task automatic test_overflow_wrap();
    logic [15:0] exp_a[4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    clear_log();
    acc_in = ACC_A;
    load_base(16'h0010);
    pulse_end();
    step();
    end_conv_layer = 1'b1;  // second layer end while writing
    step();
    end_conv_layer = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    wait_done(20, "ovf");
    checks++;
    if (wa.size() != 4 || done_cnt != 1) begin
      errors++; $display("FAIL ovf_count: writes=%0d dones=%0d want 4 1", wa.size(), done_cnt);
    end
    // Next layer follows contiguously from the advanced base.
    clear_log();
    pulse_end();
    wait_done(20, "contig");
    checks++;
    if (wa.size() != 4) begin errors++; $display("FAIL contig_count: got %0d want 4", wa.size()); end
    for (int k = 0; k < 4 && k < wa.size(); k++) begin
      checks++;
      if (wa[k] !== 16'h0014 + 16'(k)) begin
        errors++; $display("FAIL contig_a%0d: got %h want %h", k, wa[k], 16'h0014 + 16'(k));
      end
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    // Load and trigger together; address wraps modulo 2**16.
    clear_log();
    init_base_addr = 16'hFFFE;
    load_base_addr = 1'b1;
    end_conv_layer = 1'b1;
    step();
    load_base_addr = 1'b0;
    end_conv_layer = 1'b0;
    wait_done(20, "wrap");
    checks++;
    if (wa.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", wa.size()); end
    for (int k = 0; k < 4 && k < wa.size(); k++) begin
      checks++;
      if (wa[k] !== exp_a[k]) begin errors++; $display("FAIL wrap_a%0d: got %h want %h", k, wa[k], exp_a[k]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    acc_in = ACC_A;
    load_base(16'h0040);
    pulse_end();
    step();
    step();                 // lanes 0 and 1 accepted
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({wr_en, busy, done, overflow} !== 4'b0000 || wr_addr !== 16'h0000 || wr_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async: en=%b busy=%b done=%b ovf=%b addr=%h data=%h want all 0",
               wr_en, busy, done, overflow, wr_addr, wr_data);
    end
    step(); step();
    rst = 1'b1;
    repeat (10) step();
    checks++;
    if (wa.size() != 2 || done_cnt != 0) begin
      errors++; $display("FAIL rstmid_count: writes=%0d dones=%0d want 2 0", wa.size(), done_cnt);
    end
    checks++;
    if (wa.size() == 2 && (wa[0] !== 16'h0040 || wa[1] !== 16'h0041)) begin
      errors++; $display("FAIL rstmid_addr: got %h %h want 0040 0041", wa[0], wa[1]);
    end
  endtask

  task automatic test_held();
    clear_log();
    acc_in = ACC_A;
    load_base(16'h0050);
    end_conv_layer = 1'b1;
    repeat (10) step();
    end_conv_layer = 1'b0;
    wait_done(20, "held");
    repeat (5) step();
    checks++;
    if (wa.size() != 4 || done_cnt != 1 || overflow !== 1'b0) begin
      errors++; $display("FAIL held_once: writes=%0d dones=%0d ovf=%b want 4 1 0", wa.size(), done_cnt, overflow);
    end
    for (int k = 0; k < 4 && k < wa.size(); k++) begin
      checks++;
      if (wa[k] !== 16'h0050 + 16'(k)) begin
        errors++; $display("FAIL held_a%0d: got %h want %h", k, wa[k], 16'h0050 + 16'(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_backpressure();
    test_overflow_wrap();
    test_reset_mid();
    test_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
